fp_cvt_round_pack: RTL and testbench

//  Rounding/packing stage directly downstream of the integer-to-FP normaliser in the ALU convert path.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_cvt_round_pack_if.sv | 28 ++
 rtl/fp_round_decide.sv | 29 ++
 rtl/fp_cvt_round_pack.sv | 135 +++++++++++++
 tb/tb_fp_cvt_round_pack.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared FP constants for the convert/round datapaths: rounding modes, biases,
// flag positions and the per-transfer stage-1 payload of the round/pack stage.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic [10:0] FP32_BIAS = 11'd127;
    localparam logic [10:0] FP64_BIAS = 11'd1023;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] NAN_BOX = 32'hFFFF_FFFF;

    localparam int FP32_FRAC_W = 23;
    localparam int FP64_FRAC_W = 52;

    // inc holds {carry, mantissa}; FP32 uses only the low 24 bits
    typedef struct packed {
        logic        sign;
        logic [5:0]  exp;
        logic        fmt64;
        logic        zero;
        logic        nx;
        logic [52:0] inc;
    } s1_t;

endpackage

// File: rtl/fp_cvt_round_pack_if.sv
// Upstream/downstream handshake and data bundle of the round/pack stage.
// slave = the stage itself, master = whoever drives it (normaliser + consumer).
interface fp_cvt_round_pack_if #(
    parameter int DATA_WIDTH = 64,
    parameter int FLAG_WIDTH = 5
);
    logic                  in_valid;
    logic                  out_ready;
    logic                  in_sign;
    logic [5:0]            in_exp;
    logic [DATA_WIDTH-1:0] in_sig;
    logic                  in_output_fmt;
    logic [2:0]            in_rm;
    logic                  in_downstream_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [FLAG_WIDTH-1:0] out_flags;

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, in_output_fmt, in_rm, in_downstream_ready,
        output out_ready, out_valid, out_data, out_flags
    );

    modport master (
        output in_valid, in_sign, in_exp, in_sig, in_output_fmt, in_rm, in_downstream_ready,
        input  out_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_round_decide.sv
// Round-increment decision from rounding mode, sign and the L/G/S bits.
// Purely combinational so any FP rounding stage can share it.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [2:0] rm_i,
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic       guard_i,
    input  logic       sticky_i,
    output logic       round_up_o,
    output logic       inexact_o
);

    // Reserved encodings 5-7 fall back to round-to-nearest-even
    always_comb begin
        round_up_o = 1'b0;
        inexact_o  = guard_i | sticky_i;
        case (rm_i)
            RM_RNE:  round_up_o = guard_i & (sticky_i | lsb_i);
            RM_RTZ:  round_up_o = 1'b0;
            RM_RDN:  round_up_o = sign_i & (guard_i | sticky_i);
            RM_RUP:  round_up_o = ~sign_i & (guard_i | sticky_i);
            RM_RMM:  round_up_o = guard_i;
            default: round_up_o = guard_i & (sticky_i | lsb_i);
        endcase
    end

endmodule

// File: rtl/fp_cvt_round_pack.sv
// Int-to-FP convert, final stage: round a left-justified magnitude to FP32/FP64
// (stage 1), then bias, pack and NaN-box (stage 2), behind valid/ready handshakes.
module fp_cvt_round_pack
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    fp_cvt_round_pack_if.slave    bus
);

    logic                  lsb_s, guard_s, sticky_s;
    logic                  round_up_s, inexact_s, zero_s, up_s;
    logic [52:0]           inc64_s;
    logic [23:0]           inc32_s;
    s1_t                   s1_new_s, s1_d, s1_q;
    logic                  s1_valid_d, s1_valid_q;
    logic                  s2_load_s, carry_s;
    logic [10:0]           exp_b_s;
    logic [63:0]           pack_s;
    logic [FLAG_WIDTH-1:0] flags_s;
    logic                  out_valid_d, out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_d, out_data_q;
    logic [FLAG_WIDTH-1:0] out_flags_d, out_flags_q;

    // Select the L/G/S window for the target precision
    always_comb begin
        lsb_s    = 1'b0;
        guard_s  = 1'b0;
        sticky_s = 1'b0;
        if (bus.in_output_fmt) begin
            lsb_s    = bus.in_sig[11];
            guard_s  = bus.in_sig[10];
            sticky_s = |bus.in_sig[9:0];
        end else begin
            lsb_s    = bus.in_sig[40];
            guard_s  = bus.in_sig[39];
            sticky_s = |bus.in_sig[38:0];
        end
    end

    fp_round_decide u_round_decide (
        .rm_i       (bus.in_rm),
        .sign_i     (bus.in_sign),
        .lsb_i      (lsb_s),
        .guard_i    (guard_s),
        .sticky_i   (sticky_s),
        .round_up_o (round_up_s),
        .inexact_o  (inexact_s)
    );

    assign zero_s  = ~bus.in_sig[63];
    assign up_s    = round_up_s & ~zero_s;
    assign inc64_s = {1'b0, bus.in_sig[62:11]} + {52'd0, up_s};
    assign inc32_s = {1'b0, bus.in_sig[62:40]} + {23'd0, up_s};

    assign s1_new_s.sign  = bus.in_sign;
    assign s1_new_s.exp   = bus.in_exp;
    assign s1_new_s.fmt64 = bus.in_output_fmt;
    assign s1_new_s.zero  = zero_s;
    assign s1_new_s.nx    = inexact_s & ~zero_s;
    assign s1_new_s.inc   = bus.in_output_fmt ? inc64_s : {29'd0, inc32_s};

    // Stage 2 refills when empty or draining; stage 1 follows it
    assign s2_load_s     = ~out_valid_q | bus.in_downstream_ready;
    assign bus.out_ready = ~s1_valid_q | s2_load_s;

    assign carry_s = s1_q.fmt64 ? s1_q.inc[52] : s1_q.inc[23];
    assign exp_b_s = {5'd0, s1_q.exp} + (s1_q.fmt64 ? FP64_BIAS : FP32_BIAS) + {10'd0, carry_s};

    // Pack stage-1 contents into the IEEE layout
    always_comb begin
        pack_s  = 64'd0;
        flags_s = '0;
        if (s1_q.zero) begin
            pack_s = s1_q.fmt64 ? {s1_q.sign, 63'd0} : {NAN_BOX, s1_q.sign, 31'd0};
        end else if (s1_q.fmt64) begin
            pack_s = {s1_q.sign, exp_b_s, carry_s ? 52'd0 : s1_q.inc[FP64_FRAC_W-1:0]};
        end else begin
            pack_s = {NAN_BOX, s1_q.sign, exp_b_s[7:0], carry_s ? 23'd0 : s1_q.inc[FP32_FRAC_W-1:0]};
        end
        flags_s[FLAG_NX] = s1_q.nx & ~s1_q.zero;
    end

    // Next-state for both pipeline stages
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;
        if (bus.out_ready) begin
            s1_valid_d = bus.in_valid;
            s1_d       = bus.in_valid ? s1_new_s : s1_q;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d  = pack_s;
                out_flags_d = flags_s;
            end else begin
                out_data_d  = out_data_q;
                out_flags_d = out_flags_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_cvt_round_pack.sv
// Bench for fp_cvt_round_pack: directed spec vectors, backpressure, mid-stream
// reset and randomized traffic against an arithmetic rounding model.
module tb_fp_cvt_round_pack;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_cvt_round_pack_if bus ();
    fp_cvt_round_pack dut (.in_clk(clk), .in_rst(rst), .bus(bus));

    int          n_vec = 0;
    int          n_err = 0;
    int          n_acc = 0;
    logic [68:0] exp_q[$];
    logic [68:0] next_exp;
    logic        hold_v = 1'b0;
    logic [68:0] hold_val;

    task automatic chk(input string tag, input logic [68:0] obs, input logic [68:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: round the p-bit significand by comparing the discarded tail with one half
    function automatic logic [68:0] ref_model(input logic s, input logic [5:0] e,
                                              input logic [63:0] sig, input logic f64,
                                              input logic [2:0] rm);
        int          p, ex;
        logic [63:0] one, m, r, half, frac;
        logic        up, nx;
        logic [10:0] eb;
        one = 64'd1;
        if (!sig[63]) return f64 ? {5'd0, s, 63'd0} : {5'd0, 32'hFFFF_FFFF, s, 31'd0};
        p    = f64 ? 53 : 24;
        m    = sig >> (64 - p);
        r    = sig & ((one << (64 - p)) - one);
        half = one << (63 - p);
        nx   = (r != 64'd0);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s && nx;
            3'd3:    up = !s && nx;
            3'd4:    up = (r >= half);
            default: up = (r > half) || (r == half && m[0]);
        endcase
        m  = m + {63'd0, up};
        ex = int'(e) + (f64 ? 1023 : 127);
        if (m == (one << p)) begin
            m  = m >> 1;
            ex = ex + 1;
        end
        frac = m - (one << (p - 1));
        eb   = ex[10:0];
        if (f64) return {4'd0, nx, s, eb, frac[51:0]};
        return {4'd0, nx, 32'hFFFF_FFFF, s, eb[7:0], frac[22:0]};
    endfunction

    task automatic drive(input logic v, input logic s, input logic [5:0] e, input logic [63:0] sig,
                         input logic f64, input logic [2:0] rm, input logic [68:0] expv);
        bus.in_valid      = v;
        bus.in_sign       = s;
        bus.in_exp        = e;
        bus.in_sig        = sig;
        bus.in_output_fmt = f64;
        bus.in_rm         = rm;
        next_exp          = expv;
    endtask

    // One clock: check stall stability and drained results, log acceptances
    task automatic cycle();
        logic [68:0] front;
        @(negedge clk);
        if (hold_v) begin
            chk("stall_hold", {bus.out_flags, bus.out_data}, hold_val);
            chk("stall_valid", {68'd0, bus.out_valid}, 69'd1);
        end
        hold_v   = bus.out_valid && !bus.in_downstream_ready;
        hold_val = {bus.out_flags, bus.out_data};
        if (bus.out_valid && bus.in_downstream_ready) begin
            chk("output_expected", {68'd0, exp_q.size() != 0}, 69'd1);
            if (exp_q.size() != 0) begin
                front = exp_q.pop_front();
                chk("result", {bus.out_flags, bus.out_data}, front);
            end
        end
        if (bus.in_valid && bus.out_ready) begin
            exp_q.push_back(next_exp);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        drive(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 3'd0, 69'd0);
        bus.in_downstream_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) cycle();
        chk(tag, 69'(exp_q.size()), 69'd0);
    endtask

    initial begin
        logic        s, f64, v;
        logic [5:0]  e;
        logic [2:0]  rm;
        logic [63:0] sig, mask;
        drive(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 3'd0, 69'd0);
        bus.in_downstream_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", {68'd0, bus.out_valid}, 69'd0);
        chk("reset_out_data", {5'd0, bus.out_data}, 69'd0);
        chk("reset_out_flags", {64'd0, bus.out_flags}, 69'd0);
        chk("reset_out_ready", {68'd0, bus.out_ready}, 69'd1);

        // Latency: accept edge, one register stage, then out_valid
        drive(1'b1, 1'b0, 6'd0, 64'h8000_0000_0000_0000, 1'b1, 3'd0, {5'd0, 64'h3FF0_0000_0000_0000});
        cycle();
        chk("latency_1", {68'd0, bus.out_valid}, 69'd0);
        drive(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 3'd0, 69'd0);
        cycle();
        chk("latency_2", {68'd0, bus.out_valid}, 69'd1);
        cycle();

        // Spec vectors streamed back to back
        drive(1'b1, 1'b0, 6'd24, 64'h8000_0080_0000_0000, 1'b0, 3'd0, {5'd1, 64'hFFFF_FFFF_4B80_0000}); cycle();
        drive(1'b1, 1'b0, 6'd24, 64'h8000_0080_0000_0000, 1'b0, 3'd3, {5'd1, 64'hFFFF_FFFF_4B80_0001}); cycle();
        drive(1'b1, 1'b0, 6'd24, 64'hFFFF_FF80_0000_0000, 1'b0, 3'd0, {5'd1, 64'hFFFF_FFFF_4C00_0000}); cycle();
        drive(1'b1, 1'b0, 6'd24, 64'hFFFF_FF80_0000_0000, 1'b0, 3'd1, {5'd1, 64'hFFFF_FFFF_4BFF_FFFF}); cycle();
        drive(1'b1, 1'b1, 6'd24, 64'h8000_0080_0000_0000, 1'b0, 3'd2, {5'd1, 64'hFFFF_FFFF_CB80_0001}); cycle();
        drive(1'b1, 1'b1, 6'd24, 64'h8000_0080_0000_0000, 1'b0, 3'd3, {5'd1, 64'hFFFF_FFFF_CB80_0000}); cycle();
        drive(1'b1, 1'b0, 6'd0, 64'd0, 1'b1, 3'd0, {5'd0, 64'h0000_0000_0000_0000}); cycle();
        drive(1'b1, 1'b0, 6'd0, 64'd0, 1'b0, 3'd3, {5'd0, 64'hFFFF_FFFF_0000_0000}); cycle();
        drain("directed_drain");

        // Backpressure: third offer must be refused while both stages are full
        bus.in_downstream_ready = 1'b0;
        n_acc = 0;
        drive(1'b1, 1'b0, 6'd40, 64'hC123_4567_89AB_CDEF, 1'b1, 3'd0, ref_model(1'b0, 6'd40, 64'hC123_4567_89AB_CDEF, 1'b1, 3'd0));
        cycle();
        drive(1'b1, 1'b1, 6'd12, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 3'd4, ref_model(1'b1, 6'd12, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 3'd4));
        cycle();
        drive(1'b1, 1'b0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3, ref_model(1'b0, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd3));
        #1;
        chk("bp_out_ready", {68'd0, bus.out_ready}, 69'd0);
        cycle();
        cycle();
        chk("bp_accepted", 69'(n_acc), 69'd2);
        bus.in_downstream_ready = 1'b1;
        cycle();
        drain("bp_drain");

        // Mid-stream reset drops everything in flight
        bus.in_downstream_ready = 1'b0;
        drive(1'b1, 1'b0, 6'd5, 64'h9000_0000_0000_0001, 1'b1, 3'd0, 69'd0);
        cycle();
        cycle();
        drive(1'b0, 1'b0, 6'd0, 64'd0, 1'b0, 3'd0, 69'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", {68'd0, bus.out_valid}, 69'd0);
        chk("rst_mid_out_data", {5'd0, bus.out_data}, 69'd0);
        exp_q.delete();
        hold_v = 1'b0;
        bus.in_downstream_ready = 1'b1;
        repeat (5) cycle();
        chk("rst_mid_quiet", {68'd0, bus.out_valid}, 69'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 600; i++) begin
            bus.in_downstream_ready = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 3) != 0);
            s   = 1'($urandom_range(0, 1));
            e   = 6'($urandom_range(0, 63));
            f64 = 1'($urandom_range(0, 1));
            rm  = 3'($urandom_range(0, 7));
            sig = {$urandom, $urandom};
            sig[63] = 1'b1;
            mask = ~64'd0 << $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) sig = sig & mask;
            if ($urandom_range(0, 7) == 0) sig = 64'd0;
            drive(v, s, e, sig, f64, rm, ref_model(s, e, sig, f64, rm));
            cycle();
        end
        drain("random_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
